// File: rtl/mmu_l1tlb_sched_pkg.sv
// Shared types and widths for the L1 TLB request scheduler.
package mmu_l1tlb_sched_pkg;

    localparam int unsigned REQ_W         = 79;
    localparam int unsigned SFENCE_W      = 39;
    localparam int unsigned OUTST_MAX_DEF = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FLUSH
    } state_e;

endpackage

// File: rtl/mmu_l1tlb_sched_if.sv
// Handshake bundle between requesters, scheduler and L1 TLB.
// slave: scheduler side; master: requesters plus TLB side.
interface mmu_l1tlb_sched_if;
    import mmu_l1tlb_sched_pkg::*;

    logic                i_ifu_req_valid_1;
    logic                o_ifu_req_ready_1;
    logic [REQ_W-1:0]    i_ifu_req_data_79;

    logic                i_lsu_req_valid_1;
    logic                o_lsu_req_ready_1;
    logic [REQ_W-1:0]    i_lsu_req_data_79;

    logic                i_sfence_valid_1;
    logic                o_sfence_ready_1;
    logic [SFENCE_W-1:0] i_sfence_data_39;

    logic                o_tlb_req_valid_1;
    logic                i_tlb_req_ready_1;
    logic [REQ_W-1:0]    o_tlb_req_data_79;

    logic                o_tlb_sfence_valid_1;
    logic                i_tlb_sfence_ready_1;
    logic [SFENCE_W-1:0] o_tlb_sfence_data_39;

    modport slave (
        input  i_ifu_req_valid_1, i_ifu_req_data_79,
        input  i_lsu_req_valid_1, i_lsu_req_data_79,
        input  i_sfence_valid_1, i_sfence_data_39,
        input  i_tlb_req_ready_1, i_tlb_sfence_ready_1,
        output o_ifu_req_ready_1, o_lsu_req_ready_1, o_sfence_ready_1,
        output o_tlb_req_valid_1, o_tlb_req_data_79,
        output o_tlb_sfence_valid_1, o_tlb_sfence_data_39
    );

    modport master (
        output i_ifu_req_valid_1, i_ifu_req_data_79,
        output i_lsu_req_valid_1, i_lsu_req_data_79,
        output i_sfence_valid_1, i_sfence_data_39,
        output i_tlb_req_ready_1, i_tlb_sfence_ready_1,
        input  o_ifu_req_ready_1, o_lsu_req_ready_1, o_sfence_ready_1,
        input  o_tlb_req_valid_1, o_tlb_req_data_79,
        input  o_tlb_sfence_valid_1, o_tlb_sfence_data_39
    );

endinterface

// File: rtl/mmu_l1tlb_rr_arb2.sv
// IFU/LSU grant: round-robin with last-grant register, or fixed LSU priority
// when MMU_L1TLB_SCHED_LSU_PRIO_EN is defined.
module mmu_l1tlb_rr_arb2 (
    input  logic clk,
    input  logic rstn,
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic ifu_acc,
    input  logic lsu_acc,
    output logic ifu_gnt,
    output logic lsu_gnt
);

`ifdef MMU_L1TLB_SCHED_LSU_PRIO_EN
    assign lsu_gnt = 1'b1;
    assign ifu_gnt = !lsu_valid;
`else
    logic last_lsu_q, last_lsu_d;

    always_comb begin
        last_lsu_d = last_lsu_q;
        if (ifu_acc) begin
            last_lsu_d = 1'b0;
        end else if (lsu_acc) begin
            last_lsu_d = 1'b1;
        end
    end

    // Resets to LSU so the IFU wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end

    // A grant is independent of the grantee's own valid; the other side's valid decides.
    assign ifu_gnt = !lsu_valid || last_lsu_q;
    assign lsu_gnt = !ifu_valid || !last_lsu_q;
`endif

endmodule

// File: rtl/mmu_l1tlb_sched.sv
// L1 TLB request scheduler: arbitration, in-flight bound and SFENCE drain/flush.
// Optional MMU_L1TLB_SCHED_LSU_PRIO_EN selects fixed LSU priority.
module mmu_l1tlb_sched
    import mmu_l1tlb_sched_pkg::*;
#(
    parameter int unsigned OUTST_MAX = OUTST_MAX_DEF,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                clk,
    input  logic                rstn,
    mmu_l1tlb_sched_if.slave    bus,
    input  logic                i_resp_done_1,
    output logic [CNT_W-1:0]    o_outst_cnt,
    output logic                o_err_1
);

    state_e              state_q, state_d;
    logic                alive_q;
    logic                req_valid_q, req_valid_d;
    logic [REQ_W-1:0]    req_data_q, req_data_d;
    logic [SFENCE_W-1:0] sf_data_q, sf_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                can_accept, ifu_gnt, lsu_gnt;
    logic                ifu_acc, lsu_acc, req_acc, sf_acc, tlb_hs, tlb_sf_valid;

    mmu_l1tlb_rr_arb2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .ifu_valid (bus.i_ifu_req_valid_1),
        .lsu_valid (bus.i_lsu_req_valid_1),
        .ifu_acc   (ifu_acc),
        .lsu_acc   (lsu_acc),
        .ifu_gnt   (ifu_gnt),
        .lsu_gnt   (lsu_gnt)
    );

    // alive_q keeps every ready low while in reset and for the release cycle.
    assign can_accept = alive_q && (state_q == RUN) && !bus.i_sfence_valid_1
                        && (cnt_q < CNT_W'(OUTST_MAX))
                        && (!req_valid_q || bus.i_tlb_req_ready_1);

    assign bus.o_ifu_req_ready_1 = can_accept && ifu_gnt;
    assign bus.o_lsu_req_ready_1 = can_accept && lsu_gnt;
    assign bus.o_sfence_ready_1  = alive_q && (state_q == RUN);

    assign ifu_acc = bus.i_ifu_req_valid_1 && bus.o_ifu_req_ready_1;
    assign lsu_acc = bus.i_lsu_req_valid_1 && bus.o_lsu_req_ready_1;
    assign req_acc = ifu_acc || lsu_acc;
    assign sf_acc  = bus.i_sfence_valid_1 && bus.o_sfence_ready_1;
    assign tlb_hs  = req_valid_q && bus.i_tlb_req_ready_1;

    always_comb begin
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        if (tlb_hs) begin
            req_valid_d = 1'b0;
        end
        if (ifu_acc) begin
            req_valid_d = 1'b1;
            req_data_d  = bus.i_ifu_req_data_79;
        end else if (lsu_acc) begin
            req_valid_d = 1'b1;
            req_data_d  = bus.i_lsu_req_data_79;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (i_resp_done_1 && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
        if (req_acc && !i_resp_done_1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!req_acc && i_resp_done_1 && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        sf_data_d    = sf_data_q;
        tlb_sf_valid = 1'b0;
        unique case (state_q)
            RUN: begin
                if (sf_acc) begin
                    state_d   = DRAIN;
                    sf_data_d = bus.i_sfence_data_39;
                end
            end
            DRAIN: begin
                if ((cnt_q == '0) && !req_valid_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                tlb_sf_valid = 1'b1;
                if (bus.i_tlb_sfence_ready_1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            alive_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            sf_data_q   <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            alive_q     <= 1'b1;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            sf_data_q   <= sf_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_tlb_req_valid_1    = req_valid_q;
    assign bus.o_tlb_req_data_79    = req_data_q;
    assign bus.o_tlb_sfence_valid_1 = tlb_sf_valid;
    assign bus.o_tlb_sfence_data_39 = sf_data_q;
    assign o_outst_cnt              = cnt_q;
    assign o_err_1                  = err_q;

endmodule

// File: tb/tb_mmu_l1tlb_sched.sv
// Bench for mmu_l1tlb_sched: directed scenarios plus random traffic against a
// transaction-level model checked every cycle on the falling edge.
module tb_mmu_l1tlb_sched;
    import mmu_l1tlb_sched_pkg::*;

    localparam int unsigned MAXO = 4;
    localparam int unsigned CW   = 3;
    localparam logic [REQ_W-1:0]    DA = 79'h5A5A_0000_1111_2222_0001;
    localparam logic [REQ_W-1:0]    DB = 79'h3C3C_FFFF_0000_1234_0002;
    localparam logic [REQ_W-1:0]    DC = 79'h1111_2222_3333_4444_0003;
    localparam logic [REQ_W-1:0]    DF1 = 79'h0F0F_0F0F_0F0F_0F0F_0004;
    localparam logic [REQ_W-1:0]    DF2 = 79'h7070_7070_7070_7070_0005;
    localparam logic [SFENCE_W-1:0] DS = 39'h12_3456_789A;

    logic          clk = 1'b0;
    logic          rstn;
    logic          resp_done;
    logic [CW-1:0] cnt;
    logic          err;

    mmu_l1tlb_sched_if bus ();

    mmu_l1tlb_sched #(.OUTST_MAX(MAXO), .CNT_W(CW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus),
        .i_resp_done_1 (resp_done),
        .o_outst_cnt   (cnt),
        .o_err_1       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REQ_W-1:0] rand_req();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[REQ_W-1:0];
    endfunction

    function automatic logic [SFENCE_W-1:0] rand_sf();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[SFENCE_W-1:0];
    endfunction

    // Model: queue of requests waiting at the TLB port, in-flight count, mode 0/1/2.
    logic [REQ_W-1:0]    m_q[$];
    int                  m_cnt, m_mode;
    bit                  m_alive, m_err, m_last_lsu;
    bit                  m_ifu_acc, m_lsu_acc, m_sf_acc;
    logic [SFENCE_W-1:0] m_sf;

    always @(negedge clk) begin
        bit can, e_ifu, e_lsu, e_sf, ifu_a, lsu_a, sf_a, drained, any_acc;
        if (!rstn) begin
            m_q.delete();
            m_cnt = 0; m_mode = 0; m_alive = 0; m_err = 0; m_last_lsu = 1;
            m_ifu_acc = 0; m_lsu_acc = 0; m_sf_acc = 0; m_sf = '0;
            chk("rst_ifu_ready", bus.o_ifu_req_ready_1, 0);
            chk("rst_lsu_ready", bus.o_lsu_req_ready_1, 0);
            chk("rst_sf_ready", bus.o_sfence_ready_1, 0);
            chk("rst_tlb_valid", bus.o_tlb_req_valid_1, 0);
            chk("rst_tlb_data", bus.o_tlb_req_data_79, 0);
            chk("rst_tlb_sf_valid", bus.o_tlb_sfence_valid_1, 0);
            chk("rst_tlb_sf_data", bus.o_tlb_sfence_data_39, 0);
            chk("rst_cnt", cnt, 0);
            chk("rst_err", err, 0);
        end else begin
            can = m_alive && m_mode == 0 && !bus.i_sfence_valid_1 && m_cnt < MAXO
                  && (m_q.size() == 0 || bus.i_tlb_req_ready_1);
`ifdef MMU_L1TLB_SCHED_LSU_PRIO_EN
            e_ifu = can && !bus.i_lsu_req_valid_1;
            e_lsu = can;
`else
            e_ifu = can && (!bus.i_lsu_req_valid_1 || m_last_lsu);
            e_lsu = can && (!bus.i_ifu_req_valid_1 || !m_last_lsu);
`endif
            e_sf = m_alive && m_mode == 0;
            chk("ifu_ready", bus.o_ifu_req_ready_1, e_ifu);
            chk("lsu_ready", bus.o_lsu_req_ready_1, e_lsu);
            chk("sf_ready", bus.o_sfence_ready_1, e_sf);
            chk("tlb_valid", bus.o_tlb_req_valid_1, m_q.size() != 0);
            if (m_q.size() != 0) chk("tlb_data", bus.o_tlb_req_data_79, m_q[0]);
            chk("tlb_sf_valid", bus.o_tlb_sfence_valid_1, m_mode == 2);
            if (m_mode == 2) chk("tlb_sf_data", bus.o_tlb_sfence_data_39, m_sf);
            chk("cnt", cnt, m_cnt);
            chk("err", err, m_err);

            ifu_a = bus.i_ifu_req_valid_1 && e_ifu;
            lsu_a = bus.i_lsu_req_valid_1 && e_lsu;
            sf_a  = bus.i_sfence_valid_1 && e_sf;
            any_acc = ifu_a || lsu_a;
            drained = m_cnt == 0 && m_q.size() == 0;
            if (m_q.size() != 0 && bus.i_tlb_req_ready_1) void'(m_q.pop_front());
            if (ifu_a) begin m_q.push_back(bus.i_ifu_req_data_79); m_last_lsu = 0; end
            if (lsu_a) begin m_q.push_back(bus.i_lsu_req_data_79); m_last_lsu = 1; end
            if (resp_done && m_cnt == 0) m_err = 1;
            if (any_acc && !resp_done) m_cnt++;
            else if (!any_acc && resp_done && m_cnt > 0) m_cnt--;
            case (m_mode)
                0: if (sf_a) begin m_mode = 1; m_sf = bus.i_sfence_data_39; end
                1: if (drained) m_mode = 2;
                default: if (bus.i_tlb_sfence_ready_1) m_mode = 0;
            endcase
            m_alive = 1;
            m_ifu_acc = ifu_a; m_lsu_acc = lsu_a; m_sf_acc = sf_a;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_ifu_req_valid_1 = 0; bus.i_ifu_req_data_79 = '0;
        bus.i_lsu_req_valid_1 = 0; bus.i_lsu_req_data_79 = '0;
        bus.i_sfence_valid_1 = 0; bus.i_sfence_data_39 = '0;
        bus.i_tlb_req_ready_1 = 0; bus.i_tlb_sfence_ready_1 = 0;
        resp_done = 0;
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        repeat (3) cyc();
        rstn = 1;
        #2 chk("sf_ready_release", bus.o_sfence_ready_1, 0);
        cyc();
        chk("sf_ready_after", bus.o_sfence_ready_1, 1);

        // Both requesters busy, completions every cycle: strict alternation.
        bus.i_ifu_req_valid_1 = 1; bus.i_ifu_req_data_79 = DA;
        bus.i_lsu_req_valid_1 = 1; bus.i_lsu_req_data_79 = DB;
        bus.i_tlb_req_ready_1 = 1;
        for (int k = 0; k < 8; k++) begin
            resp_done = (k > 0);
            #2;
            chk("rr_ifu_ready", bus.o_ifu_req_ready_1, (k % 2) == 0);
            chk("rr_lsu_ready", bus.o_lsu_req_ready_1, (k % 2) == 1);
            if (k > 0) begin
                chk("rr_tlb_valid", bus.o_tlb_req_valid_1, 1);
                chk("rr_tlb_data", bus.o_tlb_req_data_79, (k % 2) == 1 ? DA : DB);
                chk("rr_cnt", cnt, 1);
            end
            cyc();
        end
        bus.i_ifu_req_valid_1 = 0; bus.i_lsu_req_valid_1 = 0; resp_done = 1;
        cyc();
        resp_done = 0;
        cyc();

        // Outstanding bound.
        bus.i_ifu_req_valid_1 = 1; bus.i_ifu_req_data_79 = DC;
        for (int k = 0; k < 5; k++) begin
            #2 chk("bound_ready", bus.o_ifu_req_ready_1, k < 4);
            cyc();
        end
        chk("bound_peak", cnt, 4);
        resp_done = 1;
        #2 chk("bound_ready_resp", bus.o_ifu_req_ready_1, 0);
        cyc();
        resp_done = 0;
        #2 chk("bound_one_more", bus.o_ifu_req_ready_1, 1);
        chk("bound_cnt3", cnt, 3);
        cyc();
        #2 chk("bound_full_again", bus.o_ifu_req_ready_1, 0);
        chk("bound_cnt4", cnt, 4);
        bus.i_ifu_req_valid_1 = 0; resp_done = 1;
        repeat (4) cyc();
        resp_done = 0;
        chk("bound_cnt0", cnt, 0);

        // Sfence with two outstanding, IFU valid alongside.
        bus.i_ifu_req_valid_1 = 1; bus.i_ifu_req_data_79 = DC;
        cyc(); cyc();
        bus.i_sfence_valid_1 = 1; bus.i_sfence_data_39 = DS;
        #2 chk("sf_win_sf_ready", bus.o_sfence_ready_1, 1);
        chk("sf_win_ifu_ready", bus.o_ifu_req_ready_1, 0);
        cyc();
        bus.i_sfence_valid_1 = 0; bus.i_sfence_data_39 = '0; resp_done = 1;
        #2 chk("drain_ifu_ready", bus.o_ifu_req_ready_1, 0);
        chk("drain_sf_ready", bus.o_sfence_ready_1, 0);
        cyc(); cyc();
        resp_done = 0;
        #2 chk("drain_no_flush_yet", bus.o_tlb_sfence_valid_1, 0);
        cyc();
        #2 chk("flush_valid", bus.o_tlb_sfence_valid_1, 1);
        chk("flush_data", bus.o_tlb_sfence_data_39, DS);
        chk("flush_ifu_ready", bus.o_ifu_req_ready_1, 0);
        cyc();
        bus.i_tlb_sfence_ready_1 = 1;
        #2 chk("flush_hold", bus.o_tlb_sfence_valid_1, 1);
        cyc();
        bus.i_tlb_sfence_ready_1 = 0;
        #2 chk("run_ifu_ready", bus.o_ifu_req_ready_1, 1);
        cyc();
        bus.i_ifu_req_valid_1 = 0; resp_done = 1;
        cyc();
        resp_done = 0;

        // TLB backpressure with a full register.
        bus.i_ifu_req_valid_1 = 1; bus.i_ifu_req_data_79 = DF1; bus.i_tlb_req_ready_1 = 0;
        #2 chk("bp_first_ready", bus.o_ifu_req_ready_1, 1);
        cyc();
        bus.i_ifu_req_data_79 = DF2;
        for (int k = 0; k < 5; k++) begin
            #2 chk("bp_ready", bus.o_ifu_req_ready_1, 0);
            chk("bp_data", bus.o_tlb_req_data_79, DF1);
            cyc();
        end
        bus.i_tlb_req_ready_1 = 1; resp_done = 1;
        #2 chk("bp_release_ready", bus.o_ifu_req_ready_1, 1);
        cyc();
        bus.i_ifu_req_valid_1 = 0; resp_done = 0;
        #2 chk("inc_dec_cnt", cnt, 1);
        chk("bp_next_data", bus.o_tlb_req_data_79, DF2);
        cyc();
        resp_done = 1;
        cyc();

        // Stray completion, then reset while flushing.
        #2 chk("err_clear", err, 0);
        cyc();
        resp_done = 0;
        #2 chk("err_set", err, 1);
        chk("err_cnt0", cnt, 0);
        bus.i_sfence_valid_1 = 1; bus.i_sfence_data_39 = DS;
        cyc();
        bus.i_sfence_valid_1 = 0;
        cyc();
        #2 chk("sf_t2_flush", bus.o_tlb_sfence_valid_1, 1);
        rstn = 0;
        #1 chk("mid_rst_sf_valid", bus.o_tlb_sfence_valid_1, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_sf_data", bus.o_tlb_sfence_data_39, 0);
        chk("mid_rst_tlb_data", bus.o_tlb_req_data_79, 0);
        idle_inputs();
        cyc();
        rstn = 1;
        cyc();
        #2 chk("post_rst_run", bus.o_sfence_ready_1, 1);
        cyc();

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rstn = 0;
                idle_inputs();
                cyc(); cyc();
                rstn = 1;
                cyc();
            end
            if (!bus.i_ifu_req_valid_1 || m_ifu_acc) begin
                bus.i_ifu_req_valid_1 = ($urandom % 3) != 0;
                bus.i_ifu_req_data_79 = rand_req();
            end
            if (!bus.i_lsu_req_valid_1 || m_lsu_acc) begin
                bus.i_lsu_req_valid_1 = ($urandom % 3) != 0;
                bus.i_lsu_req_data_79 = rand_req();
            end
            if (!bus.i_sfence_valid_1 || m_sf_acc) begin
                bus.i_sfence_valid_1 = ($urandom % 50) == 0;
                bus.i_sfence_data_39 = rand_sf();
            end
            bus.i_tlb_req_ready_1    = ($urandom % 4) != 0;
            bus.i_tlb_sfence_ready_1 = ($urandom % 2) != 0;
            resp_done = (m_cnt > 0) && (($urandom % 2) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
